// File: rtl/wb_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, and multi-cycle
// results wait in a small in-order queue, with a starvation stall and pending-hit lookups.
module wb_write_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int QDEPTH     = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              wb_rw,
    input  logic [ADDR_W-1:0] wb_da,
    input  logic [DATA_W-1:0] wb_d,
    input  logic              mc_valid,
    input  logic [ADDR_W-1:0] mc_da,
    input  logic [DATA_W-1:0] mc_d,
    output logic              mc_ready,
    input  logic [ADDR_W-1:0] rd_a,
    input  logic [ADDR_W-1:0] rd_b,
    output logic              pend_hit_a,
    output logic              pend_hit_b,
    output logic              stall_req,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_data,
    output logic [2:0]        pend_cnt
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int IW = (QDEPTH > 2) ? 2 : 1;

    logic [ADDR_W-1:0] q_da_q [QDEPTH];
    logic [ADDR_W-1:0] q_da_d [QDEPTH];
    logic [DATA_W-1:0] q_d_q  [QDEPTH];
    logic [DATA_W-1:0] q_d_d  [QDEPTH];
    logic [2:0]        cnt_q, cnt_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;

    logic              wb_req, grant_wb, pop, enq, keep;
    logic [2:0]        n;

    assign stall_req = (starve_q == SW'(STARVE_MAX));
    assign mc_ready  = (cnt_q < 3'(QDEPTH));
    assign pend_cnt  = cnt_q;
    assign rf_we     = rf_we_q;
    assign rf_addr   = rf_addr_q;
    assign rf_data   = rf_data_q;

    always_comb begin
        wb_req   = wb_rw && (wb_da != '0);
        grant_wb = wb_req && !stall_req;
        // Kills and pops never coincide: a pop only happens when the pipeline is not granted.
        pop      = (cnt_q != 3'd0) && !grant_wb;
        enq      = mc_valid && mc_ready && (mc_da != '0) && !(grant_wb && (mc_da == wb_da));

        keep = 1'b0;
        n    = 3'd0;
        for (int i = 0; i < QDEPTH; i++) begin
            q_da_d[i] = q_da_q[i];
            q_d_d[i]  = q_d_q[i];
        end
        // Compact survivors toward the head; reads come from _q so in-place shifting is safe.
        for (int i = 0; i < QDEPTH; i++) begin
            keep = (3'(i) < cnt_q) && !(pop && (i == 0))
                   && !(grant_wb && (q_da_q[i] == wb_da));
            if (keep) begin
                q_da_d[n[IW-1:0]] = q_da_q[i];
                q_d_d[n[IW-1:0]]  = q_d_q[i];
                n = n + 3'd1;
            end
        end
        if (enq) begin
            q_da_d[n[IW-1:0]] = mc_da;
            q_d_d[n[IW-1:0]]  = mc_d;
            n = n + 3'd1;
        end
        cnt_d = n;

        rf_we_d   = 1'b0;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        if (grant_wb) begin
            rf_we_d   = 1'b1;
            rf_addr_d = wb_da;
            rf_data_d = wb_d;
        end else if (pop) begin
            rf_we_d   = 1'b1;
            rf_addr_d = q_da_q[0];
            rf_data_d = q_d_q[0];
        end

        if (pop || (cnt_q == 3'd0))
            starve_d = '0;
        else if (!stall_req)
            starve_d = starve_q + SW'(1);
        else
            starve_d = starve_q;
    end

    always_comb begin
        pend_hit_a = 1'b0;
        pend_hit_b = 1'b0;
        for (int i = 0; i < QDEPTH; i++) begin
            if ((3'(i) < cnt_q) && (rd_a != '0) && (q_da_q[i] == rd_a)) pend_hit_a = 1'b1;
            if ((3'(i) < cnt_q) && (rd_b != '0) && (q_da_q[i] == rd_b)) pend_hit_b = 1'b1;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            cnt_q     <= 3'd0;
            starve_q  <= '0;
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_da_q[i] <= '0;
                q_d_q[i]  <= '0;
            end
        end else begin
            cnt_q     <= cnt_d;
            starve_q  <= starve_d;
            rf_we_q   <= rf_we_d;
            rf_addr_q <= rf_addr_d;
            rf_data_q <= rf_data_d;
            for (int i = 0; i < QDEPTH; i++) begin
                q_da_q[i] <= q_da_d[i];
                q_d_q[i]  <= q_d_d[i];
            end
        end
    end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: priority, queueing, kill, starvation stall and reset.
module tb_wb_write_arbiter;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic        wb_rw = 1'b0;
    logic [4:0]  wb_da = '0;
    logic [31:0] wb_d = '0;
    logic        mc_valid = 1'b0;
    logic [4:0]  mc_da = '0;
    logic [31:0] mc_d = '0;
    logic        mc_ready;
    logic [4:0]  rd_a = '0;
    logic [4:0]  rd_b = '0;
    logic        pend_hit_a, pend_hit_b, stall_req, rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [2:0]  pend_cnt;

    int tests = 0;
    int fails = 0;

    wb_write_arbiter #(.DATA_W(32), .ADDR_W(5), .QDEPTH(2), .STARVE_MAX(4)) dut (
        .CLOCK(CLOCK), .RESET(RESET),
        .wb_rw(wb_rw), .wb_da(wb_da), .wb_d(wb_d),
        .mc_valid(mc_valid), .mc_da(mc_da), .mc_d(mc_d), .mc_ready(mc_ready),
        .rd_a(rd_a), .rd_b(rd_b), .pend_hit_a(pend_hit_a), .pend_hit_b(pend_hit_b),
        .stall_req(stall_req), .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
        .pend_cnt(pend_cnt)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        rd_a = 5'd3; rd_b = 5'd4;
        #12;
        tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL rst_we got %0b exp 0", rf_we); end
        tests++; if (rf_addr !== 5'd0) begin fails++; $display("FAIL rst_addr got %0d exp 0", rf_addr); end
        tests++; if (rf_data !== 32'd0) begin fails++; $display("FAIL rst_data got %h exp 0", rf_data); end
        tests++; if (stall_req !== 1'b0) begin fails++; $display("FAIL rst_stall got %0b exp 0", stall_req); end
        tests++; if (mc_ready !== 1'b1) begin fails++; $display("FAIL rst_ready got %0b exp 1", mc_ready); end
        tests++; if (pend_cnt !== 3'd0) begin fails++; $display("FAIL rst_cnt got %0d exp 0", pend_cnt); end
        tests++; if ({pend_hit_a, pend_hit_b} !== 2'b00) begin fails++; $display("FAIL rst_hits got %b exp 00", {pend_hit_a, pend_hit_b}); end
        #1 RESET = 1'b0;
        rd_a = '0; rd_b = '0;
        step();
    endtask

    task automatic test_pipeline();
        wb_rw = 1'b1; wb_da = 5'd7; wb_d = 32'h1234_5678;
        step();
        tests++; if (rf_we !== 1'b1) begin fails++; $display("FAIL pipe_we got %0b exp 1", rf_we); end
        tests++; if (rf_addr !== 5'd7) begin fails++; $display("FAIL pipe_addr got %0d exp 7", rf_addr); end
        tests++; if (rf_data !== 32'h1234_5678) begin fails++; $display("FAIL pipe_data got %h exp 12345678", rf_data); end
        wb_da = 5'd0; wb_d = 32'hDEAD_BEEF;
        step();
        tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL pipe_r0_we got %0b exp 0", rf_we); end
        tests++; if (rf_data !== 32'h1234_5678) begin fails++; $display("FAIL pipe_hold_data got %h exp 12345678", rf_data); end
        wb_rw = 1'b0;
    endtask

    task automatic test_mc_path();
        mc_valid = 1'b1; mc_da = 5'd3; mc_d = 32'hAA; rd_a = 5'd3; rd_b = 5'd9;
        step();
        mc_valid = 1'b0;
        tests++; if (pend_cnt !== 3'd1) begin fails++; $display("FAIL mc_cnt1 got %0d exp 1", pend_cnt); end
        tests++; if (pend_hit_a !== 1'b1) begin fails++; $display("FAIL mc_hit_a got %0b exp 1", pend_hit_a); end
        tests++; if (pend_hit_b !== 1'b0) begin fails++; $display("FAIL mc_hit_b got %0b exp 0", pend_hit_b); end
        tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL mc_early_we got %0b exp 0", rf_we); end
        step();
        tests++; if ({rf_we, rf_addr, rf_data} !== {1'b1, 5'd3, 32'hAA}) begin fails++; $display("FAIL mc_write got we=%0b a=%0d d=%h exp 1/3/aa", rf_we, rf_addr, rf_data); end
        tests++; if (pend_cnt !== 3'd0) begin fails++; $display("FAIL mc_cnt0 got %0d exp 0", pend_cnt); end
        tests++; if (pend_hit_a !== 1'b0) begin fails++; $display("FAIL mc_hit_clr got %0b exp 0", pend_hit_a); end
        rd_a = '0; rd_b = '0;
    endtask

    task automatic test_r0_mc();
        mc_valid = 1'b1; mc_da = 5'd0; mc_d = 32'h55;
        step();
        mc_valid = 1'b0;
        tests++; if (pend_cnt !== 3'd0) begin fails++; $display("FAIL r0_mc_cnt got %0d exp 0", pend_cnt); end
        step();
        tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL r0_mc_we got %0b exp 0", rf_we); end
    endtask

    task automatic test_starve();
        wb_rw = 1'b1; wb_da = 5'd10; wb_d = 32'hB0;
        mc_valid = 1'b1; mc_da = 5'd1; mc_d = 32'h01;
        step();
        mc_da = 5'd2; mc_d = 32'h02;
        step();
        mc_valid = 1'b0;
        tests++; if (mc_ready !== 1'b0) begin fails++; $display("FAIL stv_ready got %0b exp 0", mc_ready); end
        tests++; if (pend_cnt !== 3'd2) begin fails++; $display("FAIL stv_cnt2 got %0d exp 2", pend_cnt); end
        step(); step();
        tests++; if (stall_req !== 1'b0) begin fails++; $display("FAIL stv_early got %0b exp 0", stall_req); end
        tests++; if ({rf_we, rf_addr} !== {1'b1, 5'd10}) begin fails++; $display("FAIL stv_wb_grant got we=%0b a=%0d exp 1/10", rf_we, rf_addr); end
        step();
        tests++; if (stall_req !== 1'b1) begin fails++; $display("FAIL stv_stall got %0b exp 1", stall_req); end
        step();
        tests++; if ({rf_we, rf_addr, rf_data} !== {1'b1, 5'd1, 32'h01}) begin fails++; $display("FAIL stv_pop got we=%0b a=%0d d=%h exp 1/1/01", rf_we, rf_addr, rf_data); end
        tests++; if ({stall_req, pend_cnt} !== {1'b0, 3'd1}) begin fails++; $display("FAIL stv_after got stall=%0b cnt=%0d exp 0/1", stall_req, pend_cnt); end
        step();
        tests++; if ({rf_we, rf_addr, rf_data} !== {1'b1, 5'd10, 32'hB0}) begin fails++; $display("FAIL stv_held got we=%0b a=%0d d=%h exp 1/10/b0", rf_we, rf_addr, rf_data); end
        wb_rw = 1'b0;
        step();
        tests++; if ({rf_we, rf_addr, rf_data, pend_cnt} !== {1'b1, 5'd2, 32'h02, 3'd0}) begin fails++; $display("FAIL stv_drain got we=%0b a=%0d d=%h cnt=%0d exp 1/2/02/0", rf_we, rf_addr, rf_data, pend_cnt); end
    endtask

    task automatic test_kill();
        wb_rw = 1'b1; wb_da = 5'd9; wb_d = 32'h99;
        mc_valid = 1'b1; mc_da = 5'd5; mc_d = 32'h11;
        step();
        mc_valid = 1'b0;
        wb_da = 5'd5; wb_d = 32'h22; rd_a = 5'd5;
        #1;
        tests++; if (pend_hit_a !== 1'b1) begin fails++; $display("FAIL kill_hit_pre got %0b exp 1", pend_hit_a); end
        step();
        tests++; if ({rf_we, rf_addr, rf_data} !== {1'b1, 5'd5, 32'h22}) begin fails++; $display("FAIL kill_write got we=%0b a=%0d d=%h exp 1/5/22", rf_we, rf_addr, rf_data); end
        tests++; if ({pend_cnt, pend_hit_a} !== {3'd0, 1'b0}) begin fails++; $display("FAIL kill_clear got cnt=%0d hit=%0b exp 0/0", pend_cnt, pend_hit_a); end
        // Same-cycle handshake to the granted register is consumed and dropped.
        wb_da = 5'd6; wb_d = 32'h66;
        mc_valid = 1'b1; mc_da = 5'd6; mc_d = 32'h77;
        step();
        mc_valid = 1'b0; wb_rw = 1'b0;
        tests++; if (pend_cnt !== 3'd0) begin fails++; $display("FAIL kill_same_cnt got %0d exp 0", pend_cnt); end
        step();
        tests++; if (rf_we !== 1'b0) begin fails++; $display("FAIL kill_no_stale got %0b exp 0", rf_we); end
        rd_a = '0;
    endtask

    task automatic test_back_to_back();
        wb_rw = 1'b1; wb_da = 5'd20; wb_d = 32'h20;
        mc_valid = 1'b1; mc_da = 5'd11; mc_d = 32'hA1;
        step();
        mc_da = 5'd12; mc_d = 32'hA2;
        step();
        wb_rw = 1'b0;
        mc_da = 5'd13; mc_d = 32'hA3;
        tests++; if (mc_ready !== 1'b0) begin fails++; $display("FAIL b2b_full got %0b exp 0", mc_ready); end
        step();
        tests++; if ({rf_we, rf_addr, rf_data, pend_cnt, mc_ready} !== {1'b1, 5'd11, 32'hA1, 3'd1, 1'b1}) begin fails++; $display("FAIL b2b_first got we=%0b a=%0d d=%h cnt=%0d rdy=%0b exp 1/11/a1/1/1", rf_we, rf_addr, rf_data, pend_cnt, mc_ready); end
        step();
        mc_valid = 1'b0;
        tests++; if ({rf_we, rf_addr, rf_data, pend_cnt} !== {1'b1, 5'd12, 32'hA2, 3'd1}) begin fails++; $display("FAIL b2b_second got we=%0b a=%0d d=%h cnt=%0d exp 1/12/a2/1", rf_we, rf_addr, rf_data, pend_cnt); end
        step();
        tests++; if ({rf_we, rf_addr, rf_data, pend_cnt} !== {1'b1, 5'd13, 32'hA3, 3'd0}) begin fails++; $display("FAIL b2b_third got we=%0b a=%0d d=%h cnt=%0d exp 1/13/a3/0", rf_we, rf_addr, rf_data, pend_cnt); end
    endtask

    task automatic test_reset_mid();
        wb_rw = 1'b1; wb_da = 5'd15; wb_d = 32'hF0;
        mc_valid = 1'b1; mc_da = 5'd16; mc_d = 32'h16;
        step();
        mc_da = 5'd17; mc_d = 32'h17;
        step();
        mc_valid = 1'b0;
        tests++; if (pend_cnt !== 3'd2) begin fails++; $display("FAIL rmid_pre got %0d exp 2", pend_cnt); end
        #2 RESET = 1'b1;
        #1;
        tests++; if ({pend_cnt, rf_we, mc_ready} !== {3'd0, 1'b0, 1'b1}) begin fails++; $display("FAIL rmid_async got cnt=%0d we=%0b rdy=%0b exp 0/0/1", pend_cnt, rf_we, mc_ready); end
        wb_rw = 1'b0;
        #3 RESET = 1'b0;
        step(); step();
        tests++; if ({rf_we, pend_cnt} !== {1'b0, 3'd0}) begin fails++; $display("FAIL rmid_post got we=%0b cnt=%0d exp 0/0", rf_we, pend_cnt); end
    endtask

    initial begin
        test_reset();
        test_pipeline();
        test_mc_path();
        test_r0_mc();
        test_starve();
        test_kill();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
